vga_text_console: RTL and testbench
===================================

VGA_TEXT_CONSOLE -- requirements
Module: vga_text_console

Interface
REQ-001 Parameter COLS, default 80, number of text columns per row.
REQ-002 Parameter ROWS, default 60, number of text rows.
REQ-003 Parameter BLANK, default 8'h20, character code written when erasing a cell.
REQ-004 CLK_50M  input  1  sole clock; every register updates on its rising edge.
REQ-005 RESET_N  input  1  reset, synchronous and active-low, sampled on the CLK_50M rising edge.
REQ-006 char_in  input  8  character code offered for display.
REQ-007 char_valid  input  1  char_in is valid this cycle.
REQ-008 char_ready  output  1  block can accept a character this cycle.
REQ-009 clear_req  input  1  level request to blank the whole screen and home the cursor.
REQ-010 mem_addr  output  13  map-RAM write address {row[5:0], col[6:0]}.
REQ-011 mem_we_v  output  1  map-RAM write enable, one-cycle pulse per write.
REQ-012 b  output  8  map-RAM write data (character code).
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 cursor_row  output  6  current cursor row, range 0..ROWS-1.
REQ-015 cursor_col  output  7  current cursor column, range 0..COLS-1.

Function
REQ-016 The FSM SHALL have states IDLE, LINECLR and SCRCLR; char_ready = (state==IDLE) && !clear_req, combinational.
REQ-017 A character is accepted on an edge where char_valid && char_ready; the block sustains one accept per cycle while in IDLE.
REQ-018 mem_addr, b and mem_we_v SHALL be registered; the write caused by an accept at edge N appears with mem_we_v=1 in the cycle after edge N. mem_addr and b hold their last value when mem_we_v=0.
REQ-019 Code 8'h0D SHALL set col=0 with no write and stay in IDLE.
REQ-020 Code 8'h0A SHALL set col=0 and row=(row+1) mod ROWS with no write, then enter LINECLR.
REQ-021 Code 8'h08 with col>0 SHALL write BLANK at {row,col-1} and set col=col-1; with col=0 it is a no-op; either way the state stays IDLE.
REQ-022 Any other code SHALL be written at {row,col}; then col=col+1, or if col==COLS-1, col=0 and row=(row+1) mod ROWS followed by entry to LINECLR.
REQ-023 LINECLR SHALL write BLANK to {row,0}..{row,COLS-1} in ascending order, one write per cycle: exactly COLS consecutive mem_we_v pulses. It returns to IDLE on the edge that issues the last write.
REQ-024 In IDLE with clear_req=1, the block SHALL enter SCRCLR; clear_req has priority over char_valid in the same cycle, so no character is accepted.
REQ-025 SCRCLR SHALL write BLANK to every cell in row-major order from {0,0} to {ROWS-1,COLS-1}: ROWS*COLS writes on consecutive cycles. Columns COLS..127 are never written.
REQ-026 SCRCLR SHALL set the cursor to (0,0) and return to IDLE on the edge issuing the final write.
REQ-027 clear_req asserted during LINECLR or SCRCLR SHALL be ignored until IDLE; a request still held high in IDLE starts a new SCRCLR.
REQ-028 Row wrap ROWS-1 -> 0 SHALL occur without scrolling; the new row 0 is blanked by LINECLR.
REQ-029 cursor_row and cursor_col SHALL be registered, and their updates SHALL be visible in the cycle after the accepting edge.

Reset
REQ-030 On an edge with RESET_N=0: state=IDLE, cursor=(0,0), mem_we_v=0, mem_addr=0, b=0, busy=0, clear counters=0.
REQ-031 Reset during LINECLR or SCRCLR SHALL abort the operation: mem_we_v=0 in the cycle after the reset edge and no further writes occur.
REQ-032 char_ready SHALL be 1 in the first cycle after reset release when clear_req=0.

Verification
REQ-033 After reset, send 'A' (8'h41) then 'B' (8'h42) back-to-back -> writes {0,0}=41, then {0,1}=42 on consecutive cycles; cursor=(0,2); char_ready stays 1.
REQ-034 Cursor at (3,79), send 8'h5A -> write {3,79}=5A, then 80 writes of 20 at {4,0}..{4,79}; char_ready is low for 80 cycles; cursor=(4,0).
REQ-035 Cursor at (59,10), send 8'h0A -> no character write; 80 writes of 20 to row 0; cursor=(0,0).
REQ-036 Cursor at (2,5), send 8'h08 -> write {2,4}=20; cursor=(2,4). Cursor at (2,0), send 8'h08 -> no write; cursor unchanged.
REQ-037 Raise clear_req and char_valid together in IDLE -> no accept; 4800 writes of 20 (first {0,0}, last {59,79}); cursor=(0,0); busy is high throughout.
REQ-038 Assert RESET_N=0 midway through SCRCLR -> mem_we_v=0 from the next cycle; state=IDLE; cursor=(0,0).

Source files
------------

// File: rtl/vga_text_console.sv
// Text console writer: turns a character stream into character-map RAM writes,
// tracks the cursor, and blanks a line on entry and the whole screen on request.
module vga_text_console #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 60,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        CLK_50M,
    input  logic        RESET_N,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clear_req,
    output logic [12:0] mem_addr,
    output logic        mem_we_v,
    output logic [7:0]  b,
    output logic        busy,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    localparam int unsigned ROW_W  = 6;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned DATA_W = 8;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    localparam logic [DATA_W-1:0] CH_CR = 8'h0D;
    localparam logic [DATA_W-1:0] CH_LF = 8'h0A;
    localparam logic [DATA_W-1:0] CH_BS = 8'h08;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LINECLR = 2'd1,
        SCRCLR  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [ROW_W-1:0]   row_d, clr_row, clr_row_d, row_next;
    logic [COL_W-1:0]   col_d, clr_col, clr_col_d, col_prev;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  data_d;
    logic               we_d;

    // Handshake is decoded straight from state so a request is seen in the same cycle.
    assign char_ready = (state == IDLE) && !clear_req;

    assign row_next = (cursor_row == LAST_ROW) ? '0 : cursor_row + ROW_W'(1);
    assign col_prev = cursor_col - COL_W'(1);

    // Next-state, cursor, clear counters and RAM write request.
    always_comb begin
        state_d   = state;
        row_d     = cursor_row;
        col_d     = cursor_col;
        clr_row_d = clr_row;
        clr_col_d = clr_col;
        we_d      = 1'b0;
        addr_d    = mem_addr;
        data_d    = b;

        case (state)
            IDLE: begin
                clr_row_d = '0;
                clr_col_d = '0;
                if (clear_req) begin
                    state_d = SCRCLR;
                end else if (char_valid) begin
                    case (char_in)
                        CH_CR: col_d = '0;
                        CH_LF: begin
                            col_d   = '0;
                            row_d   = row_next;
                            state_d = LINECLR;
                        end
                        CH_BS: begin
                            if (cursor_col != '0) begin
                                we_d   = 1'b1;
                                addr_d = {cursor_row, col_prev};
                                data_d = BLANK;
                                col_d  = col_prev;
                            end
                        end
                        default: begin
                            we_d   = 1'b1;
                            addr_d = {cursor_row, cursor_col};
                            data_d = char_in;
                            if (cursor_col == LAST_COL) begin
                                col_d   = '0;
                                row_d   = row_next;
                                state_d = LINECLR;
                            end else begin
                                col_d = cursor_col + COL_W'(1);
                            end
                        end
                    endcase
                end
            end

            // The cursor row has already advanced, so this blanks the row just entered.
            LINECLR: begin
                we_d   = 1'b1;
                addr_d = {cursor_row, clr_col};
                data_d = BLANK;
                if (clr_col == LAST_COL) begin
                    clr_col_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_col_d = clr_col + COL_W'(1);
                end
            end

            SCRCLR: begin
                we_d   = 1'b1;
                addr_d = {clr_row, clr_col};
                data_d = BLANK;
                if (clr_col == LAST_COL) begin
                    clr_col_d = '0;
                    if (clr_row == LAST_ROW) begin
                        clr_row_d = '0;
                        row_d     = '0;
                        col_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        clr_row_d = clr_row + ROW_W'(1);
                    end
                end else begin
                    clr_col_d = clr_col + COL_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any clear in progress.
    always_ff @(posedge CLK_50M) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cursor_row <= '0;
            cursor_col <= '0;
            clr_row    <= '0;
            clr_col    <= '0;
            mem_we_v   <= 1'b0;
            mem_addr   <= '0;
            b          <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cursor_row <= row_d;
            cursor_col <= col_d;
            clr_row    <= clr_row_d;
            clr_col    <= clr_col_d;
            mem_we_v   <= we_d;
            mem_addr   <= addr_d;
            b          <= data_d;
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console: expected RAM writes are queued when a
// character or clear is driven and compared as the block emits them.
module tb_vga_text_console;

    localparam int unsigned COLS = 80;
    localparam int unsigned ROWS = 60;

    logic        CLK_50M = 1'b0;
    logic        RESET_N;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        clear_req;
    logic [12:0] mem_addr;
    logic        mem_we_v;
    logic [7:0]  b;
    logic        busy;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    vga_text_console #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
        .CLK_50M    (CLK_50M),
        .RESET_N    (RESET_N),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .mem_addr   (mem_addr),
        .mem_we_v   (mem_we_v),
        .b          (b),
        .busy       (busy),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #10 CLK_50M = ~CLK_50M;

    logic [20:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          last_wait;
    logic [5:0]  m_row;
    logic [6:0]  m_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [5:0] r, input logic [6:0] c, input logic [7:0] d);
        exp_q.push_back({r, c, d});
    endtask

    task automatic push_line(input logic [5:0] r);
        for (int c = 0; c < int'(COLS); c++) push_wr(r, 7'(c), 8'h20);
    endtask

    task automatic push_screen();
        for (int r = 0; r < int'(ROWS); r++) push_line(6'(r));
    endtask

    function automatic logic [5:0] next_row(input logic [5:0] r);
        return (r == 6'(ROWS - 1)) ? 6'd0 : r + 6'd1;
    endfunction

    // Reference behaviour of one accepted character.
    task automatic model(input logic [7:0] c);
        case (c)
            8'h0D: m_col = 7'd0;
            8'h0A: begin
                m_col = 7'd0;
                m_row = next_row(m_row);
                push_line(m_row);
            end
            8'h08: begin
                if (m_col != 7'd0) begin
                    m_col = m_col - 7'd1;
                    push_wr(m_row, m_col, 8'h20);
                end
            end
            default: begin
                push_wr(m_row, m_col, c);
                if (m_col == 7'(COLS - 1)) begin
                    m_col = 7'd0;
                    m_row = next_row(m_row);
                    push_line(m_row);
                end else begin
                    m_col = m_col + 7'd1;
                end
            end
        endcase
    endtask

    task automatic send(input logic [7:0] c);
        int w = 0;
        @(negedge CLK_50M);
        while (char_ready !== 1'b1 && w < 200) begin
            char_valid = 1'b0;
            w++;
            @(negedge CLK_50M);
        end
        last_wait = w;
        if (char_ready !== 1'b1) begin
            check("ready_timeout", 32'(char_ready), 32'd1);
            char_valid = 1'b0;
            return;
        end
        char_in    = c;
        char_valid = 1'b1;
        model(c);
        @(posedge CLK_50M);
        #1;
        check("cursor_row", 32'(cursor_row), 32'(m_row));
        check("cursor_col", 32'(cursor_col), 32'(m_col));
    endtask

    task automatic drop_valid();
        @(negedge CLK_50M);
        char_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            n++;
            @(negedge CLK_50M);
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge CLK_50M);
    endtask

    // Scoreboard: every write must match the oldest queued expectation.
    always @(negedge CLK_50M) begin : monitor
        logic [20:0] e;
        if (mem_we_v === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[20:8]));
                check("wr_data", 32'(b), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RESET_N    = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        clear_req  = 1'b0;
        m_row      = 6'd0;
        m_col      = 7'd0;

        // Reset values.
        repeat (3) @(negedge CLK_50M);
        check("rst_we", 32'(mem_we_v), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_row", 32'(cursor_row), 32'd0);
        check("rst_col", 32'(cursor_col), 32'd0);
        RESET_N = 1'b1;
        @(posedge CLK_50M);
        #1;
        check("ready_after_rst", 32'(char_ready), 32'd1);

        // Back-to-back 'A','B'.
        send(8'h41);
        send(8'h42);
        check("b2b_wait", 32'(last_wait), 32'd0);
        drop_valid();
        check("b2b_ready", 32'(char_ready), 32'd1);
        drain();

        // Backspace at column 0 and mid-line, carriage return.
        send(8'h0A);
        send(8'h0A);
        send(8'h08);
        drop_valid();
        drain();
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h08);
        send(8'h0D);
        drop_valid();
        drain();

        // Wrap at the last column triggers a line clear of the next row.
        send(8'h0A);
        for (int i = 0; i < int'(COLS) - 1; i++) send(8'h30 + 8'(i % 10));
        send(8'h5A);
        char_valid = 1'b0;
        n = 0;
        @(negedge CLK_50M);
        while (char_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge CLK_50M);
        end
        check("lineclr_ready_low", 32'(n), 32'd80);
        drain();

        // Line feed from the last row wraps to row 0 without scrolling.
        for (int i = 0; i < int'(ROWS) - 5; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h4B);
        check("row59", 32'(cursor_row), 32'd59);
        send(8'h0A);
        drop_valid();
        drain();

        // Clear has priority over a simultaneous character.
        @(negedge CLK_50M);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h51;
        #1;
        check("ready_during_clr", 32'(char_ready), 32'd0);
        push_screen();
        @(posedge CLK_50M);
        #1;
        check("busy_enter", 32'(busy), 32'd1);
        @(negedge CLK_50M);
        clear_req  = 1'b0;
        char_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            n++;
            @(negedge CLK_50M);
        end
        check("scrclr_busy_cycles", 32'(n), 32'd4800);
        drain();
        m_row = 6'd0;
        m_col = 7'd0;
        check("clr_row", 32'(cursor_row), 32'd0);
        check("clr_col", 32'(cursor_col), 32'd0);

        // Move the cursor, then abort a screen clear with reset.
        send(8'h0A);
        send(8'h41);
        drop_valid();
        drain();
        @(negedge CLK_50M);
        clear_req = 1'b1;
        push_screen();
        @(negedge CLK_50M);
        clear_req = 1'b0;
        repeat (2000) @(negedge CLK_50M);
        check("abort_busy_before", 32'(busy), 32'd1);
        RESET_N = 1'b0;
        @(posedge CLK_50M);
        #1;
        check("abort_we", 32'(mem_we_v), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_row", 32'(cursor_row), 32'd0);
        check("abort_col", 32'(cursor_col), 32'd0);
        @(negedge CLK_50M);
        RESET_N = 1'b1;
        exp_q.delete();
        repeat (50) @(negedge CLK_50M);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_ready", 32'(char_ready), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
